// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request generator: sequential fetch with valid/ready
// back-pressure, branch/jalr redirects, trap entry, MRET return and misaligned-target traps.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       PCSrc,
    input  logic [XLEN-1:0]  PCTarget,
    input  logic [XLEN-1:0]  ALUResult,
    input  logic             Stall,
    input  logic             Trap,
    input  logic             Mret,
    input  logic             FetchReady,
    output logic             FetchValid,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  PCPlus4,
    output logic [XLEN-1:0]  EPC,
    output logic             MisalignExc,
    output logic [XLEN-1:0]  MisalignAddr,
    output logic [CNT_W-1:0] FetchCount,
    output logic             DbgState
);

    // Handshake: a fetch of address PC is transferred on a rising edge where
    // FetchValid and FetchReady are both 1; while FetchValid=1 and FetchReady=0
    // the PC is held stable until the request is accepted or redirected.

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [XLEN-1:0]  maddr_q, maddr_d;
    logic             mexc_q, mexc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  jalr_tgt;
    logic             fetch_accept;
    logic             br_mis;
    logic             jalr_mis;

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic: BOOT lasts exactly one edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        FetchValid = 1'b0;
        if (state_q == RUN) FetchValid = !Stall;
    end

    assign fetch_accept = FetchValid & FetchReady;
    assign pc_plus4     = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    assign jalr_tgt     = ALUResult & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign br_mis       = (PCTarget[1:0] != 2'b00);
    assign jalr_mis     = jalr_tgt[1];

    // Next-PC selection, highest priority first
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        maddr_d = maddr_q;
        mexc_d  = 1'b0;
        if (state_q == RUN) begin
            if (Trap) begin
                epc_d = pc_q;
                pc_d  = TRAP_VECTOR;
            end else if (Mret) begin
                pc_d = epc_q;
            end else if (PCSrc == 2'b01 && br_mis) begin
                mexc_d  = 1'b1;
                maddr_d = PCTarget;
                epc_d   = pc_q;
                pc_d    = TRAP_VECTOR;
            end else if (PCSrc == 2'b10 && jalr_mis) begin
                mexc_d  = 1'b1;
                maddr_d = jalr_tgt;
                epc_d   = pc_q;
                pc_d    = TRAP_VECTOR;
            end else if (PCSrc == 2'b01) begin
                pc_d = PCTarget;
            end else if (PCSrc == 2'b10) begin
                pc_d = jalr_tgt;
            end else if (Stall) begin
                pc_d = pc_q;
            end else if (fetch_accept) begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            maddr_q <= '0;
            mexc_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            maddr_q <= maddr_d;
            mexc_q  <= mexc_d;
            if (fetch_accept) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign PC           = pc_q;
    assign PCPlus4      = pc_plus4;
    assign EPC          = epc_q;
    assign MisalignExc  = mexc_q;
    assign MisalignAddr = maddr_q;
    assign FetchCount   = cnt_q;
    assign DbgState     = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table of per-cycle inputs with
// hand-computed results, plus reset and asynchronous mid-cycle reset sequences.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [1:0]  PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic        Stall;
    logic        Trap;
    logic        Mret;
    logic        FetchReady;
    logic        FetchValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] EPC;
    logic        MisalignExc;
    logic [31:0] MisalignAddr;
    logic [31:0] FetchCount;
    logic        DbgState;

    int tests_run = 0;
    int tests_failed = 0;

    pc_fetch_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100), .CNT_W(32)
    ) dut (
        .CLK(CLK), .Reset(Reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .ALUResult(ALUResult), .Stall(Stall), .Trap(Trap), .Mret(Mret),
        .FetchReady(FetchReady), .FetchValid(FetchValid), .PC(PC),
        .PCPlus4(PCPlus4), .EPC(EPC), .MisalignExc(MisalignExc),
        .MisalignAddr(MisalignAddr), .FetchCount(FetchCount), .DbgState(DbgState)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall;
        logic        trap;
        logic        mret;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] alu;
        logic        rdy;
        logic        e_fv;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic        e_mexc;
        logic [31:0] e_maddr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic stall, logic trap, logic mret, logic [1:0] src,
                                logic [31:0] tgt, logic [31:0] alu, logic rdy,
                                logic e_fv, logic [31:0] e_pc, logic [31:0] e_epc,
                                logic e_mexc, logic [31:0] e_maddr, logic [31:0] e_cnt);
        vec_t v;
        v.stall = stall; v.trap = trap; v.mret = mret; v.src = src;
        v.tgt = tgt; v.alu = alu; v.rdy = rdy; v.e_fv = e_fv;
        v.e_pc = e_pc; v.e_epc = e_epc; v.e_mexc = e_mexc;
        v.e_maddr = e_maddr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        PCSrc = 2'b00; PCTarget = '0; ALUResult = '0;
        Stall = 1'b0; Trap = 1'b0; Mret = 1'b0; FetchReady = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        string tag;
        @(negedge CLK);
        Stall = v.stall; Trap = v.trap; Mret = v.mret; PCSrc = v.src;
        PCTarget = v.tgt; ALUResult = v.alu; FetchReady = v.rdy;
        #1;
        tag = $sformatf("v%0d", idx);
        check({tag, ".FetchValid"}, {31'b0, FetchValid}, {31'b0, v.e_fv});
        @(posedge CLK);
        #1;
        check({tag, ".PC"}, PC, v.e_pc);
        check({tag, ".PCPlus4"}, PCPlus4, v.e_pc + 32'd4);
        check({tag, ".EPC"}, EPC, v.e_epc);
        check({tag, ".MisalignExc"}, {31'b0, MisalignExc}, {31'b0, v.e_mexc});
        check({tag, ".MisalignAddr"}, MisalignAddr, v.e_maddr);
        check({tag, ".FetchCount"}, FetchCount, v.e_cnt);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".PC"}, PC, 32'h0);
        check({tag, ".FetchValid"}, {31'b0, FetchValid}, 32'h0);
        check({tag, ".EPC"}, EPC, 32'h0);
        check({tag, ".MisalignExc"}, {31'b0, MisalignExc}, 32'h0);
        check({tag, ".MisalignAddr"}, MisalignAddr, 32'h0);
        check({tag, ".FetchCount"}, FetchCount, 32'h0);
        check({tag, ".state"}, {31'b0, DbgState}, 32'h0);
    endtask

    initial begin
        // Columns: stall trap mret src tgt alu rdy | fv pc epc mexc maddr cnt
        vecs.push_back(mk(0,0,0,2'b00,32'h0,32'h0,1, 1,32'h4,32'h0,0,32'h0,1));
        vecs.push_back(mk(0,0,0,2'b00,32'h0,32'h0,1, 1,32'h8,32'h0,0,32'h0,2));
        vecs.push_back(mk(0,0,0,2'b00,32'h0,32'h0,0, 1,32'h8,32'h0,0,32'h0,2));
        vecs.push_back(mk(0,0,0,2'b00,32'h0,32'h0,0, 1,32'h8,32'h0,0,32'h0,2));
        vecs.push_back(mk(0,0,0,2'b00,32'h0,32'h0,0, 1,32'h8,32'h0,0,32'h0,2));
        vecs.push_back(mk(0,0,0,2'b00,32'h0,32'h0,1, 1,32'hC,32'h0,0,32'h0,3));
        // branch with an accepted fetch, then jalr under back-pressure
        vecs.push_back(mk(0,0,0,2'b01,32'h40,32'h0,1, 1,32'h40,32'h0,0,32'h0,4));
        vecs.push_back(mk(0,0,0,2'b10,32'h0,32'h81,0, 1,32'h80,32'h0,0,32'h0,4));
        // aligned redirect while stalled
        vecs.push_back(mk(1,0,0,2'b01,32'h10,32'h0,1, 0,32'h10,32'h0,0,32'h0,4));
        // misaligned branch, pulse clears, then mret
        vecs.push_back(mk(0,0,0,2'b01,32'h42,32'h0,0, 1,32'h100,32'h10,1,32'h42,4));
        vecs.push_back(mk(0,0,0,2'b00,32'h0,32'h0,0, 1,32'h100,32'h10,0,32'h42,4));
        vecs.push_back(mk(0,0,1,2'b00,32'h0,32'h0,0, 1,32'h10,32'h10,0,32'h42,4));
        // trap and mret together
        vecs.push_back(mk(0,0,0,2'b01,32'h20,32'h0,0, 1,32'h20,32'h10,0,32'h42,4));
        vecs.push_back(mk(0,1,1,2'b00,32'h0,32'h0,0, 1,32'h100,32'h20,0,32'h42,4));
        // trap with misaligned branch: no exception flag, fetch still counted
        vecs.push_back(mk(0,1,0,2'b01,32'h42,32'h0,1, 1,32'h100,32'h100,0,32'h42,5));
        // misaligned jalr: reported address has bit0 cleared
        vecs.push_back(mk(0,0,0,2'b10,32'h0,32'h207,0, 1,32'h100,32'h100,1,32'h206,5));
        // wrap of PC+4
        vecs.push_back(mk(0,0,0,2'b01,32'hFFFF_FFFC,32'h0,0, 1,32'hFFFF_FFFC,32'h100,0,32'h206,5));
        vecs.push_back(mk(0,0,0,2'b00,32'h0,32'h0,1, 1,32'h0,32'h100,0,32'h206,6));
        // stall suppresses fetch; reserved PCSrc behaves as sequential
        vecs.push_back(mk(1,0,0,2'b00,32'h0,32'h0,1, 0,32'h0,32'h100,0,32'h206,6));
        vecs.push_back(mk(0,0,0,2'b11,32'h500,32'h0,1, 1,32'h4,32'h100,0,32'h206,7));
        vecs.push_back(mk(0,0,0,2'b01,32'h30,32'h0,0, 1,32'h30,32'h100,0,32'h206,7));

        // Reset state
        drive_idle();
        Reset = 1'b0;
        #12;
        check_reset_state("reset");

        // Release: BOOT cycle ignores inputs and does not fetch
        @(negedge CLK);
        Reset = 1'b1;
        PCSrc = 2'b01; PCTarget = 32'h0000_0800; Trap = 1'b0;
        #1;
        check("boot.FetchValid", {31'b0, FetchValid}, 32'h0);
        @(posedge CLK);
        #1;
        check("boot.PC", PC, 32'h0);
        check("boot.FetchCount", FetchCount, 32'h0);
        check("boot.state", {31'b0, DbgState}, 32'h1);

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

        // Asynchronous reset mid-cycle at PC=0x30 with a request outstanding
        @(negedge CLK);
        drive_idle();
        FetchReady = 1'b0;
        #2;
        check("pre_areset.PC", PC, 32'h30);
        Reset = 1'b0;
        #1;
        check_reset_state("areset");
        @(negedge CLK);
        Reset = 1'b1;
        FetchReady = 1'b1;
        @(posedge CLK);
        #1;
        check("reboot.PC", PC, 32'h0);
        check("reboot.FetchCount", FetchCount, 32'h0);
        @(posedge CLK);
        #1;
        check("reboot_fetch.PC", PC, 32'h4);
        check("reboot_fetch.FetchCount", FetchCount, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
